mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the core's single memory port: instruction fetch (IFU) and load/store (LSU) share one word-wide memory bus. The block accepts one request at a time. It registers the winning request onto the memory side, waits out memory wait states via `mem_ready`, and returns the completion and read data to the requester that issued it. LSU normally has priority. A starvation counter guarantees fetch progress.

## Interface
- `STARVE_LIMIT`, default 4: consecutive contested LSU grants after which IFU wins the next contest; legal range 1..15.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high; dominates `ce`.
- `ce` in 1: clock enable; all registers update only when high.
- `ifu_req` in 1: IFU read request, held until `ifu_gnt` seen.
- `ifu_addr` in 32: IFU byte address.
- `ifu_gnt` out 1: one-cycle grant pulse; request captured.
- `ifu_rvalid` out 1: one-cycle completion pulse.
- `ifu_rdata` out 32: read data, valid with `ifu_rvalid`.
- `lsu_req` in 1: LSU request, held until `lsu_gnt` seen.
- `lsu_we` in 1: 1 = write.
- `lsu_be` in 4: byte enables.
- `lsu_addr` in 32: byte address.
- `lsu_wdata` in 32: write data.
- `lsu_gnt`, `lsu_rvalid` out 1: same meaning as the IFU outputs.
- `lsu_rdata` out 32: same meaning as `ifu_rdata`.
- `mem_req` out 1: transaction active.
- `mem_we` out 1: write strobe qualifier.
- `mem_be` out 4: byte enables (4'b1111 for IFU).
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: write data.
- `mem_ready` in 1: memory completes the transaction in the current cycle.
- `mem_rdata` in 32: read data, valid when `mem_ready` is high.

## Operation
- States: IDLE, BUSY_IFU, BUSY_LSU.
- IDLE:
  - Requests are sampled only in IDLE.
  - If only one requester is active, it wins.
  - If both are active, LSU wins unless `streak == STARVE_LIMIT`, in which case IFU wins.
  - On a win: capture address, `we`, `be` and `wdata`. IFU always captures we=0, be=1111.
  - Move to BUSY_x. Register `x_gnt` = 1 and `mem_req` = 1.
- BUSY_x:
  - `mem_*` outputs are held stable.
  - On an edge where `mem_ready` = 1: register `x_rvalid` = 1 and `mem_req` = 0, then return to IDLE.
  - For a read, `x_rdata` <= `mem_rdata`. For a write, `rdata` holds its previous value.
- Starvation counter `streak` (4 bits):
  - Increments on an LSU grant while `ifu_req` is high.
  - Clears on an LSU grant while `ifu_req` is low.
  - Clears on any IFU grant.
- `gnt` and `rvalid` are single-cycle pulses. They are cleared on the next `ce` edge.
- `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` hold their last values when idle.
- Requester rule: drop `req` in the cycle after `gnt` unless another transaction is wanted. A `req` still high in the cycle after `gnt` while the arbiter is IDLE is a new request.
- `ce` low freezes state, counter and all outputs, including pulses. `mem_ready` is ignored while `ce` is low.
- `reset` sets the state to IDLE, `streak` = 0, and all outputs to 0, including `rdata` and `mem_addr`.
- Reset mid-transaction abandons the transaction: `mem_req` drops next cycle and no `rvalid` is issued.

## Timing
- Request sampled at edge k.
- In cycle k+1, `gnt` and `mem_req` are high.
- With `mem_ready` = 1 in cycle k+1, `rvalid` and `rdata` appear in cycle k+2 and the arbiter is IDLE in k+2.
- Minimum latency from request to data is 2 cycles. Each memory wait state adds 1 cycle.
- Peak throughput is one transaction per 2 cycles. A new request is sampled at the end of the `rvalid` cycle at the earliest.
- `mem_req` never stays high for two cycles across two different transactions.
- `gnt` and `rvalid` never go to both requesters in the same cycle.

## Test plan
- IFU read of addr 0x0000_0103, `mem_ready` = 1 always, `mem_rdata` = 0xDEADBEEF:
  - `mem_addr` = 0x100 and `ifu_gnt` in cycle k+1.
  - `ifu_rvalid`, `ifu_rdata` = 0xDEADBEEF in k+2.
- LSU write, addr 0x40, be=0011, wdata 0x1234_5678, `mem_ready` low for 3 cycles:
  - `mem_*` stable for 4 cycles.
  - `lsu_rvalid` 1 cycle after `mem_ready` rises.
  - `lsu_rdata` unchanged.
- Both requesting continuously, STARVE_LIMIT=4, zero wait states:
  - Grant order LSU,LSU,LSU,LSU,IFU, then the pattern repeats.
  - Never two IFU grants in a row while LSU is requesting.
- Both requesting with `ifu_req` dropped for one LSU grant: `streak` clears, and the next IFU win needs 4 further contested LSU grants.
- Reset asserted while in BUSY_LSU with `mem_ready` = 0:
  - Next cycle: `mem_req` = 0 and all outputs 0.
  - No `lsu_rvalid` afterwards.
  - A subsequent IFU request completes normally.
- `ce` toggling 1,0,1 during a transaction with `mem_ready` = 1 during the `ce` = 0 cycle: completion is delayed until a `ce`-high edge, and the `rvalid` pulse lasts exactly one `ce`-high cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: IFU and LSU share one word-wide memory port.
// LSU normally has priority; a contested-grant streak counter forces IFU progress.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [3:0]  lsu_be,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_IFU, BUSY_LSU} state_t;

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        ifu_gnt_d, ifu_rvalid_d, lsu_gnt_d, lsu_rvalid_d;
  logic [31:0] ifu_rdata_d, lsu_rdata_d;
  logic        mem_req_d, mem_we_d;
  logic [3:0]  mem_be_d;
  logic [31:0] mem_addr_d, mem_wdata_d;

  // Memory is word addressed; the byte offset bits are dropped on capture.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ifu_addr[1:0], lsu_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    ifu_gnt_d    = 1'b0;
    lsu_gnt_d    = 1'b0;
    ifu_rvalid_d = 1'b0;
    lsu_rvalid_d = 1'b0;
    ifu_rdata_d  = ifu_rdata;
    lsu_rdata_d  = lsu_rdata;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_be_d     = mem_be;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    case (state_q)
      IDLE: begin
        if (ifu_req && (!lsu_req || streak_q == LIMIT)) begin
          state_d    = BUSY_IFU;
          ifu_gnt_d  = 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_be_d   = 4'b1111;
          mem_addr_d = {ifu_addr[31:2], 2'b00};
          streak_d   = 4'd0;
        end else if (lsu_req) begin
          state_d     = BUSY_LSU;
          lsu_gnt_d   = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = lsu_we;
          mem_be_d    = lsu_be;
          mem_addr_d  = {lsu_addr[31:2], 2'b00};
          mem_wdata_d = lsu_wdata;
          // Only grants that IFU was actually waiting on count toward starvation.
          streak_d    = ifu_req ? streak_q + 4'd1 : 4'd0;
        end
      end
      BUSY_IFU: begin
        if (mem_ready) begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          ifu_rvalid_d = 1'b1;
          ifu_rdata_d  = mem_rdata;
        end
      end
      BUSY_LSU: begin
        if (mem_ready) begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          lsu_rvalid_d = 1'b1;
          if (!mem_we) lsu_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      streak_q   <= 4'd0;
      ifu_gnt    <= 1'b0;
      lsu_gnt    <= 1'b0;
      ifu_rvalid <= 1'b0;
      lsu_rvalid <= 1'b0;
      ifu_rdata  <= 32'd0;
      lsu_rdata  <= 32'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else if (ce) begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      ifu_gnt    <= ifu_gnt_d;
      lsu_gnt    <= lsu_gnt_d;
      ifu_rvalid <= ifu_rvalid_d;
      lsu_rvalid <= lsu_rvalid_d;
      ifu_rdata  <= ifu_rdata_d;
      lsu_rdata  <= lsu_rdata_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_be     <= mem_be_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester agents push expected completions on
// grant, a monitor pops them on rvalid; inputs driven and outputs sampled on negedge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1, ce = 1'b1;
  logic        ifu_req = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_gnt, ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_req = 1'b0, lsu_we = 1'b0;
  logic [3:0]  lsu_be = 4'hf;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        who;     // 1 = IFU, 0 = LSU
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb[$];
  bit   gnt_log[$];

  int n_vec = 0, n_bad = 0;
  int wait_cfg = 0, wcnt = 0;
  bit mem_manual = 1'b0;
  int ifu_todo = 0, lsu_todo = 0, lsu_gnt_cnt = 0, ifu_drop_at = 0, ifu_hold = 0;
  int busy_cnt = 0, last_busy = 0;
  logic [31:0] lsu_model = '0;
  logic        p_req = 1'b0, p_rv = 1'b0;
  logic [36:0] p_ctl = '0;
  logic [31:0] p_wdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'hDEADBEEF + a - 32'h100;
  endfunction

  task automatic ifu_granted();
    txn_t t;
    t.who = 1'b1; t.addr = {ifu_addr[31:2], 2'b00}; t.we = 1'b0; t.be = 4'hf;
    t.wdata = '0; t.rdata = mem_fn(t.addr);
    chk("ifu_gnt_mem_req", 64'(mem_req), 64'(1'b1));
    chk("ifu_gnt_mem_ctl", 64'({mem_we, mem_be, mem_addr}), 64'({1'b0, 4'hf, t.addr}));
    sb.push_back(t);
    gnt_log.push_back(1'b1);
    ifu_todo--;
    if (ifu_todo > 0) ifu_addr = ifu_addr + 32'd4;
    else ifu_req = 1'b0;
  endtask

  task automatic lsu_granted();
    txn_t t;
    t.who = 1'b0; t.addr = {lsu_addr[31:2], 2'b00}; t.we = lsu_we; t.be = lsu_be;
    t.wdata = lsu_wdata;
    t.rdata = lsu_we ? lsu_model : mem_fn(t.addr);
    lsu_model = t.rdata;
    chk("lsu_gnt_mem_req", 64'(mem_req), 64'(1'b1));
    chk("lsu_gnt_mem_ctl", 64'({mem_we, mem_be, mem_addr}), 64'({t.we, t.be, t.addr}));
    if (t.we) chk("lsu_gnt_mem_wdata", 64'(mem_wdata), 64'(t.wdata));
    sb.push_back(t);
    gnt_log.push_back(1'b0);
    lsu_gnt_cnt++;
    if (ifu_drop_at != 0 && lsu_gnt_cnt == ifu_drop_at) begin
      ifu_req  = 1'b0;
      ifu_hold = 2;
    end
    lsu_todo--;
    if (lsu_todo > 0) lsu_addr = lsu_addr + 32'd4;
    else lsu_req = 1'b0;
  endtask

  task automatic tick();
    logic e_ce, e_rst, e_rdy, exp_rv, fresh, any_rv;
    txn_t t;
    @(negedge clk);
    e_ce = ce; e_rst = reset; e_rdy = mem_ready;
    any_rv = ifu_rvalid | lsu_rvalid;
    exp_rv = e_rst ? 1'b0 : (e_ce ? (p_req & e_rdy) : p_rv);
    chk("rvalid_timing", 64'(any_rv), 64'(exp_rv));
    fresh = e_ce & ~e_rst;
    if (ifu_gnt | lsu_gnt) chk("gnt_exclusive", 64'(ifu_gnt & lsu_gnt), 64'(1'b0));
    if (any_rv) chk("rvalid_exclusive", 64'(ifu_rvalid & lsu_rvalid), 64'(1'b0));
    if (fresh && any_rv) begin
      if (sb.size() == 0) chk("rvalid_unexpected", 64'(any_rv), 64'(1'b0));
      else begin
        t = sb.pop_front();
        chk("rvalid_who", 64'({ifu_rvalid, lsu_rvalid}), 64'(t.who ? 2'b10 : 2'b01));
        chk("rdata", 64'(t.who ? ifu_rdata : lsu_rdata), 64'(t.rdata));
      end
    end
    if (fresh && mem_req && p_req) begin
      chk("mem_ctl_stable", 64'({mem_we, mem_be, mem_addr}), 64'(p_ctl));
      chk("mem_wdata_stable", 64'(mem_wdata), 64'(p_wdata));
      busy_cnt++;
    end
    if (fresh && mem_req && !p_req) busy_cnt = 1;
    if (fresh && !mem_req && p_req) last_busy = busy_cnt;
    if (ifu_hold > 0) begin
      ifu_hold--;
      if (ifu_hold == 0) ifu_req = 1'b1;
    end
    if (fresh && ifu_gnt) ifu_granted();
    if (fresh && lsu_gnt) lsu_granted();
    if (!mem_manual) begin
      if (mem_req) begin
        mem_ready = (wcnt >= wait_cfg);
        wcnt++;
      end else begin
        wcnt = 0;
        mem_ready = 1'b0;
      end
    end
    mem_rdata = mem_fn(mem_addr);
    p_req = mem_req; p_rv = any_rv;
    p_ctl = {mem_we, mem_be, mem_addr}; p_wdata = mem_wdata;
  endtask

  task automatic do_reset();
    reset = 1'b1; ifu_req = 1'b0; lsu_req = 1'b0; ifu_todo = 0; lsu_todo = 0;
    tick();
    chk("rst_ctl", 64'({ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we, mem_be}), 64'(0));
    chk("rst_ifu_rdata", 64'(ifu_rdata), 64'(0));
    chk("rst_lsu_rdata", 64'(lsu_rdata), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    reset = 1'b0;
    sb.delete(); gnt_log.delete();
    lsu_model = '0; lsu_gnt_cnt = 0; ifu_hold = 0;
  endtask

  task automatic run_until_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (ifu_todo == 0 && lsu_todo == 0 && sb.size() == 0 && !mem_req && ifu_hold == 0);
    end
    chk("idle_reached", 64'(done), 64'(1'b1));
  endtask

  initial begin
    bit exp3[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit exp4[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    bit got;

    // IFU read, zero wait states, unaligned address
    do_reset();
    wait_cfg = 0; ifu_addr = 32'h0000_0103; ifu_todo = 1; ifu_req = 1'b1;
    tick();
    chk("t1_gnt", 64'(ifu_gnt), 64'(1'b1));
    chk("t1_mem_addr", 64'(mem_addr), 64'(32'h100));
    tick();
    chk("t1_rvalid", 64'(ifu_rvalid), 64'(1'b1));
    chk("t1_rdata", 64'(ifu_rdata), 64'(32'hDEADBEEF));
    run_until_idle(20);

    // LSU read, then LSU write with three wait states
    lsu_we = 1'b0; lsu_be = 4'hf; lsu_addr = 32'h80; lsu_wdata = '0;
    lsu_todo = 1; lsu_req = 1'b1;
    run_until_idle(20);
    lsu_we = 1'b1; lsu_be = 4'b0011; lsu_addr = 32'h40; lsu_wdata = 32'h1234_5678;
    wait_cfg = 3; lsu_todo = 1; lsu_req = 1'b1;
    run_until_idle(30);
    chk("t2_busy_cycles", 64'(last_busy), 64'(4));
    chk("t2_rdata_hold", 64'(lsu_rdata), 64'(mem_fn(32'h80)));
    wait_cfg = 0;

    // reset while LSU transaction waits on memory
    wait_cfg = 10; lsu_we = 1'b0; lsu_be = 4'hf; lsu_addr = 32'h200;
    lsu_todo = 1; lsu_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = lsu_gnt;
    end
    chk("t5_gnt_seen", 64'(got), 64'(1'b1));
    tick(); tick();
    chk("t5_busy", 64'(mem_req), 64'(1'b1));
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    wait_cfg = 0; ifu_addr = 32'h300; ifu_todo = 1; ifu_req = 1'b1;
    run_until_idle(20);

    // clock enable freezing a transaction and its pulses
    mem_manual = 1'b1; mem_ready = 1'b0;
    ifu_addr = 32'h404; ifu_todo = 1; ifu_req = 1'b1;
    tick();
    chk("t6_gnt", 64'(ifu_gnt), 64'(1'b1));
    ce = 1'b0; mem_ready = 1'b1;
    tick();
    chk("t6_gnt_frozen", 64'(ifu_gnt), 64'(1'b1));
    chk("t6_no_rv_ce0", 64'(ifu_rvalid), 64'(1'b0));
    ce = 1'b1; mem_ready = 1'b0;
    tick();
    chk("t6_gnt_cleared", 64'(ifu_gnt), 64'(1'b0));
    chk("t6_still_busy", 64'(mem_req), 64'(1'b1));
    mem_ready = 1'b1;
    tick();
    chk("t6_rvalid", 64'(ifu_rvalid), 64'(1'b1));
    ce = 1'b0; mem_ready = 1'b0;
    tick();
    chk("t6_rv_frozen", 64'(ifu_rvalid), 64'(1'b1));
    ce = 1'b1;
    tick();
    chk("t6_rv_one_cycle", 64'(ifu_rvalid), 64'(1'b0));
    mem_manual = 1'b0;
    run_until_idle(10);

    // continuous contention: starvation limit forces every fifth grant to IFU
    do_reset();
    wait_cfg = 0; ifu_addr = 32'h1000; ifu_todo = 2;
    lsu_we = 1'b0; lsu_be = 4'hf; lsu_addr = 32'h2000; lsu_todo = 8;
    ifu_req = 1'b1; lsu_req = 1'b1;
    run_until_idle(100);
    chk("t3_gnt_count", 64'(gnt_log.size()), 64'(10));
    for (int i = 0; i < 10; i++)
      if (i < gnt_log.size()) chk($sformatf("t3_gnt%0d", i), 64'(gnt_log[i]), 64'(exp3[i]));

    // IFU drops out for one LSU grant: streak restarts from zero
    do_reset();
    ifu_drop_at = 2; ifu_addr = 32'h3000; ifu_todo = 1;
    lsu_addr = 32'h4000; lsu_todo = 8;
    ifu_req = 1'b1; lsu_req = 1'b1;
    run_until_idle(100);
    ifu_drop_at = 0;
    chk("t4_gnt_count", 64'(gnt_log.size()), 64'(9));
    for (int i = 0; i < 9; i++)
      if (i < gnt_log.size()) chk($sformatf("t4_gnt%0d", i), 64'(gnt_log[i]), 64'(exp4[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
